// File: rtl/conv_result_writer.sv
// Convolution result writer: buffers engine results in a FWFT FIFO and drains them as DMA write bursts.
// Optional macro CONV_WR_RELU_EN clamps negative results to zero as they enter the FIFO.
module conv_result_writer #(
  parameter int DEPTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [31:0]       res_data,
  input  logic              res_valid,
  output logic              res_ready,
  output logic [31:0]       dma_wdata,
  output logic [ADDR_W-1:0] dma_waddr,
  output logic              dma_wvalid,
  input  logic              dma_wready,
  output logic              dma_wlast,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | accepting results, waiting for enough data to form a burst
  // BURST | issuing the latched number of write beats
  // FIN   | one-cycle done pulse
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int BW = $clog2(BURST_LEN + 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic [BW-1:0]     blen_q, blen_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic [31:0]       mem_q [DEPTH];

  logic              full, in_xfer, push, pop, last_beat, burst_go;
  logic [CNT_W-1:0]  remaining, want;
  logic [31:0]       wr_val;

`ifdef CONV_WR_RELU_EN
  assign wr_val = res_data[31] ? 32'h0000_0000 : res_data;
`else
  assign wr_val = res_data;
`endif

  assign full       = (occ_q == OW'(DEPTH));
  assign in_xfer    = (state_q == S_RUN) || (state_q == S_BURST);
  assign res_ready  = in_xfer && !full && (acc_q < count_q);
  assign push       = res_valid && res_ready;
  assign dma_wvalid = (state_q == S_BURST);
  assign pop        = dma_wvalid && dma_wready;
  assign last_beat  = (beat_q == blen_q - BW'(1));

  // Head of the FIFO and the address only change on a pop, so they hold under backpressure.
  assign dma_wdata  = dma_wvalid ? mem_q[rptr_q] : 32'h0;
  assign dma_waddr  = dma_wvalid ? base_q + (ADDR_W'(sent_q) << 2) : '0;
  assign dma_wlast  = dma_wvalid && last_beat;
  assign busy       = in_xfer;
  assign done       = (state_q == S_FIN);

  assign remaining  = count_q - sent_q;
  assign want       = (remaining < CNT_W'(BURST_LEN)) ? remaining : CNT_W'(BURST_LEN);
  assign burst_go   = (remaining != '0) && (CNT_W'(occ_q) >= want);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    acc_d   = push ? acc_q + CNT_W'(1) : acc_q;
    sent_d  = sent_q;
    blen_d  = blen_q;
    beat_d  = beat_q;
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    occ_d   = occ_q + OW'(push) - OW'(pop);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = cfg_base;
          count_d = cfg_count;
          acc_d   = '0;
          sent_d  = '0;
          state_d = (cfg_count == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (burst_go) begin
          state_d = S_BURST;
          blen_d  = BW'(want);
          beat_d  = '0;
        end
      end
      S_BURST: begin
        if (pop) begin
          sent_d = sent_q + CNT_W'(1);
          beat_d = beat_q + BW'(1);
          if (last_beat) begin
            state_d = (sent_q + CNT_W'(1) == count_q) ? S_FIN : S_RUN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      count_q <= '0;
      acc_q   <= '0;
      sent_q  <= '0;
      blen_q  <= '0;
      beat_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      sent_q  <= sent_d;
      blen_q  <= blen_d;
      beat_q  <= beat_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
    end
  end

  // Storage needs no reset; pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_val;
  end

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed testbench for conv_result_writer; expectations follow the CONV_WR_RELU_EN setting.
module tb_conv_result_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_base = '0;
  logic [15:0] cfg_count = '0;
  logic [31:0] res_data = '0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [31:0] dma_wdata;
  logic [15:0] dma_waddr;
  logic        dma_wvalid;
  logic        dma_wready = 1'b0;
  logic        dma_wlast;
  logic        busy;
  logic        done;

  conv_result_writer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_count(cfg_count),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .dma_wdata(dma_wdata), .dma_waddr(dma_waddr), .dma_wvalid(dma_wvalid),
    .dma_wready(dma_wready), .dma_wlast(dma_wlast), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_hs_cyc = 0;
  int acc_cnt = 0;
  bit busy_seen = 0;
  bit wvalid_seen = 0;
  bit idle_nonzero = 0;
  logic [15:0] q_addr [$];
  logic [31:0] q_data [$];
  logic        q_last [$];
  logic [31:0] pvals [16];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe at the falling edge; a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      if (dma_wvalid && dma_wready) begin
        q_addr.push_back(dma_waddr);
        q_data.push_back(dma_wdata);
        q_last.push_back(dma_wlast);
        last_hs_cyc = cyc;
      end
      if (res_valid && res_ready) acc_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_seen = 1;
      if (dma_wvalid) wvalid_seen = 1;
      if (!dma_wvalid && (dma_wdata !== 32'h0 || dma_waddr !== 16'h0 || dma_wlast !== 1'b0))
        idle_nonzero = 1;
    end
  end

  function automatic logic [31:0] xf(input logic [31:0] v);
`ifdef CONV_WR_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] base, input logic [15:0] count);
    q_addr.delete();
    q_data.delete();
    q_last.delete();
    done_cnt = 0;
    acc_cnt = 0;
    busy_seen = 0;
    wvalid_seen = 0;
    cfg_base = base;
    cfg_count = count;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_values(input int n);
    int t;
    bit timed_out;
    timed_out = 0;
    for (int i = 0; i < n; i++) begin
      res_data = pvals[i];
      res_valid = 1'b1;
      t = 0;
      while (!res_ready && t < 300) begin
        tick();
        t++;
      end
      if (t >= 300) begin
        timed_out = 1;
        break;
      end
      tick();
    end
    res_valid = 1'b0;
    res_data = '0;
    n_checks++;
    if (timed_out) $display("FAIL push_timeout: res_ready stayed low, wanted %0d accepts", n);
    else n_pass++;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_cnt < 1 && t < 400) begin
      tick();
      t++;
    end
    repeat (4) tick();
    n_checks++;
    if (done_cnt !== 1) $display("FAIL %s_done_count: got %0d, want 1", name, done_cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({res_ready, dma_wvalid, dma_wlast, busy, done} !== 5'b0)
      $display("FAIL reset_ctrl: got %b, want 00000", {res_ready, dma_wvalid, dma_wlast, busy, done});
    else n_pass++;
    n_checks++;
    if (dma_wdata !== 32'h0 || dma_waddr !== 16'h0)
      $display("FAIL reset_data: got data=%h addr=%h, want 0", dma_wdata, dma_waddr);
    else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] ea;
    logic [31:0] ed;
    logic el;
    pvals[0] = 32'd5;
    pvals[1] = 32'hFFFF_FFFD;
    pvals[2] = 32'h7FFF_FFFF;
    pvals[3] = 32'h8000_0000;
    dma_wready = 1'b1;
    start_job(16'h0100, 16'd4);
    push_values(4);
    wait_done("basic");
    n_checks++;
    if (q_addr.size() !== 4) $display("FAIL basic_beats: got %0d, want 4", q_addr.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      ea = 16'h0100 + 16'(4 * i);
      ed = xf(pvals[i]);
      el = (i == 3);
      n_checks++;
      if (i >= q_addr.size()) $display("FAIL basic_beat%0d: got none, want addr=%h data=%h", i, ea, ed);
      else if (q_addr[i] !== ea || q_data[i] !== ed || q_last[i] !== el)
        $display("FAIL basic_beat%0d: got addr=%h data=%h last=%b, want addr=%h data=%h last=%b",
                 i, q_addr[i], q_data[i], q_last[i], ea, ed, el);
      else n_pass++;
    end
    n_checks++;
    if (done_cyc !== last_hs_cyc + 1)
      $display("FAIL basic_done_latency: got cycle %0d, want %0d", done_cyc, last_hs_cyc + 1);
    else n_pass++;
  endtask

  task automatic test_split();
    logic [15:0] ea;
    logic [31:0] ed;
    logic el;
    for (int i = 0; i < 6; i++) pvals[i] = 32'h0000_1000 + 32'(i);
    dma_wready = 1'b1;
    start_job(16'h0000, 16'd6);
    // A second start while the job runs must be ignored.
    cfg_base = 16'h9000;
    cfg_count = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    push_values(6);
    wait_done("split");
    n_checks++;
    if (q_addr.size() !== 6) $display("FAIL split_beats: got %0d, want 6", q_addr.size());
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      ea = 16'(4 * i);
      ed = xf(pvals[i]);
      el = (i == 3) || (i == 5);
      n_checks++;
      if (i >= q_addr.size()) $display("FAIL split_beat%0d: got none, want addr=%h data=%h", i, ea, ed);
      else if (q_addr[i] !== ea || q_data[i] !== ed || q_last[i] !== el)
        $display("FAIL split_beat%0d: got addr=%h data=%h last=%b, want addr=%h data=%h last=%b",
                 i, q_addr[i], q_data[i], q_last[i], ea, ed, el);
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL split_busy_after: got %b, want 0", busy);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] ea;
    logic [31:0] ed;
    logic el;
    bit unstable;
    for (int i = 0; i < 10; i++) pvals[i] = 32'h0000_0100 + 32'(i * 17);
    dma_wready = 1'b0;
    unstable = 0;
    start_job(16'h0040, 16'd10);
    fork
      push_values(10);
      begin
        for (int c = 0; c < 30; c++) begin
          tick();
          if (dma_wvalid && (dma_waddr !== 16'h0040 || dma_wdata !== xf(pvals[0]) || dma_wlast !== 1'b0))
            unstable = 1;
        end
        n_checks++;
        if (acc_cnt !== 8) $display("FAIL bp_accepts: got %0d, want 8", acc_cnt);
        else n_pass++;
        n_checks++;
        if (res_ready !== 1'b0 || dma_wvalid !== 1'b1)
          $display("FAIL bp_stall: got res_ready=%b wvalid=%b, want 0 1", res_ready, dma_wvalid);
        else n_pass++;
        n_checks++;
        if (unstable) $display("FAIL bp_stable: got changing beat, want addr=0040 data=%h held", xf(pvals[0]));
        else n_pass++;
        dma_wready = 1'b1;
      end
    join
    wait_done("bp");
    n_checks++;
    if (q_addr.size() !== 10) $display("FAIL bp_beats: got %0d, want 10", q_addr.size());
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      ea = 16'h0040 + 16'(4 * i);
      ed = xf(pvals[i]);
      el = (i == 3) || (i == 7) || (i == 9);
      n_checks++;
      if (i >= q_addr.size()) $display("FAIL bp_beat%0d: got none, want addr=%h data=%h", i, ea, ed);
      else if (q_addr[i] !== ea || q_data[i] !== ed || q_last[i] !== el)
        $display("FAIL bp_beat%0d: got addr=%h data=%h last=%b, want addr=%h data=%h last=%b",
                 i, q_addr[i], q_data[i], q_last[i], ea, ed, el);
      else n_pass++;
    end
  endtask

  task automatic test_zero();
    dma_wready = 1'b1;
    start_job(16'h0500, 16'd0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL zero_done_cycle: got done=%b busy=%b, want 1 0", done, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0) $display("FAIL zero_done_width: got %b, want 0", done);
    else n_pass++;
    repeat (4) tick();
    n_checks++;
    if (done_cnt !== 1 || busy_seen !== 1'b0 || wvalid_seen !== 1'b0)
      $display("FAIL zero_quiet: got done_cnt=%0d busy_seen=%b wvalid_seen=%b, want 1 0 0",
               done_cnt, busy_seen, wvalid_seen);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [15:0] ea;
    logic [31:0] ed;
    for (int i = 0; i < 4; i++) pvals[i] = 32'h0123_0000 + 32'(i);
    dma_wready = 1'b1;
    start_job(16'hFFF8, 16'd4);
    push_values(4);
    wait_done("wrap");
    for (int i = 0; i < 4; i++) begin
      ea = (i == 0) ? 16'hFFF8 : (i == 1) ? 16'hFFFC : (i == 2) ? 16'h0000 : 16'h0004;
      ed = xf(pvals[i]);
      n_checks++;
      if (i >= q_addr.size()) $display("FAIL wrap_beat%0d: got none, want addr=%h", i, ea);
      else if (q_addr[i] !== ea || q_data[i] !== ed)
        $display("FAIL wrap_beat%0d: got addr=%h data=%h, want addr=%h data=%h",
                 i, q_addr[i], q_data[i], ea, ed);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ea;
    logic [31:0] ed;
    logic el;
    int t;
    for (int i = 0; i < 4; i++) pvals[i] = 32'h0AAA_0000 + 32'(i);
    dma_wready = 1'b0;
    start_job(16'h0300, 16'd4);
    push_values(4);
    dma_wready = 1'b1;
    t = 0;
    while (q_addr.size() < 2 && t < 50) begin
      tick();
      t++;
    end
    dma_wready = 1'b0;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({res_ready, dma_wvalid, dma_wlast, busy, done} !== 5'b0 || dma_wdata !== 32'h0 || dma_waddr !== 16'h0)
      $display("FAIL midrst_outputs: got ctrl=%b data=%h addr=%h, want all 0",
               {res_ready, dma_wvalid, dma_wlast, busy, done}, dma_wdata, dma_waddr);
    else n_pass++;
    n_checks++;
    if (q_addr.size() !== 2) $display("FAIL midrst_beats_before: got %0d, want 2", q_addr.size());
    else n_pass++;
    rst = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (done_cnt !== 0) $display("FAIL midrst_no_done: got %0d, want 0", done_cnt);
    else n_pass++;
    for (int i = 0; i < 4; i++) pvals[i] = 32'h0555_0000 + 32'(i);
    dma_wready = 1'b1;
    start_job(16'h0200, 16'd4);
    push_values(4);
    wait_done("midrst");
    n_checks++;
    if (q_addr.size() !== 4) $display("FAIL midrst_new_beats: got %0d, want 4", q_addr.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      ea = 16'h0200 + 16'(4 * i);
      ed = xf(pvals[i]);
      el = (i == 3);
      n_checks++;
      if (i >= q_addr.size()) $display("FAIL midrst_beat%0d: got none, want addr=%h data=%h", i, ea, ed);
      else if (q_addr[i] !== ea || q_data[i] !== ed || q_last[i] !== el)
        $display("FAIL midrst_beat%0d: got addr=%h data=%h last=%b, want addr=%h data=%h last=%b",
                 i, q_addr[i], q_data[i], q_last[i], ea, ed, el);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split();
    test_backpressure();
    test_zero();
    test_wrap();
    test_reset_mid();
    n_checks++;
    if (idle_nonzero) $display("FAIL idle_outputs: got nonzero data/addr/last with wvalid low, want 0");
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
